// File: rtl/lut_stream_decoder_pkg.sv
// lut_stream_decoder_pkg
//    Shared constants for the LUT stream decoder: the push-code encoding
//    seen on the push_code input, the one-bit tag stored alongside each
//    buffered symbol, and a constant-foldable log2 helper used to size
//    FIFO pointers and counters.
package lut_stream_decoder_pkg;

    // Push-code encoding on the push_code input
    localparam logic [1:0] PC_IDLE = 2'd0;
    localparam logic [1:0] PC_SYM  = 2'd1;
    localparam logic [1:0] PC_LIT  = 2'd2;
    localparam logic [1:0] PC_LUT  = 2'd3;

    // Entry tag stored in the FIFO MSB above the symbol bits
    localparam logic TAG_LOOKUP  = 1'b0;
    localparam logic TAG_LITERAL = 1'b1;

    // Ceiling log2, usable in parameter context; bounded loop keeps it
    // synthesizable.
    function automatic int clog2f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lut_stream_decoder_fifo.sv
// sd_fifo
//    Synchronous first-word-fall-through FIFO used to buffer tagged input
//    symbols ahead of the decoder's S1 stage.
//    Ports:
//       clk, rst   clock and synchronous active-high reset
//       push_i     write din_i (ignored when already holding DEPTH entries)
//       pop_i      drop the head entry (ignored when empty)
//       din_i      entry to write
//       dout_o     current head entry, valid whenever empty_o is low
//       empty_o    no entries held
//       count_o    number of entries held (0..DEPTH)
module sd_fifo
    import lut_stream_decoder_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [WIDTH-1:0]          din_i,
    output logic [WIDTH-1:0]          dout_o,
    output logic                      empty_o,
    output logic [clog2f(DEPTH):0]    count_o
);

    localparam int AW = clog2f(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             doPush;
    logic             doPop;

    // Guard the requests locally so the pointers can never run past the
    // stored data, whatever the caller does.
    assign doPush  = push_i && (count_q != CW'(DEPTH));
    assign doPop   = pop_i && (count_q != '0);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem[rdPtr_q];

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + CW'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage array has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/lut_stream_decoder.sv
// lut_stream_decoder
//    Table-driven symbol decoder. Symbols and literals are buffered in a
//    FIFO, staged through S1, then emitted one per cycle either translated
//    through a runtime-loadable LUT or passed through as literals.
//    Ports:
//       clk, rst     clock and synchronous active-high reset
//       push_code    0 idle, 1 lookup symbol, 2 literal, 3 LUT write
//       d            symbol, literal or LUT write data
//       full         FIFO holds FIFO_DEPTH entries
//       half_full    FIFO holds at least FIFO_DEPTH/2 entries
//       lut_counter  next LUT write address
//       overflow     sticky flag: a push was dropped while full
//       q            decoded word, valid while push_out is high
//       push_out     one-cycle valid strobe for q
//       stall        downstream backpressure
module lut_stream_decoder
    import lut_stream_decoder_pkg::*;
#(
    parameter int WIDTH_IN   = 8,
    parameter int WIDTH_OUT  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           push_code,
    input  logic [WIDTH_IN-1:0]  d,
    output logic                 full,
    output logic                 half_full,
    output logic [WIDTH_IN-1:0]  lut_counter,
    output logic                 overflow,
    output logic [WIDTH_OUT-1:0] q,
    output logic                 push_out,
    input  logic                 stall
);

    localparam int AW       = clog2f(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int EW       = WIDTH_IN + 1;
    localparam int LUT_SIZE = 2 ** WIDTH_IN;

    logic [WIDTH_OUT-1:0] lut [LUT_SIZE];

    logic [CW-1:0]        fifoCount;
    logic                 fifoEmpty;
    logic [EW-1:0]        fifoDin;
    logic [EW-1:0]        fifoDout;
    logic                 fifoPush;
    logic                 fifoPop;
    logic                 isPush;
    logic                 isLutWrite;
    logic                 fire;

    logic                 valid1_q, valid1_d;
    logic                 tag1_q, tag1_d;
    logic [WIDTH_IN-1:0]  sym1_q, sym1_d;

    logic [WIDTH_IN-1:0]  lutCounter_q;
    logic                 overflow_q;
    logic [WIDTH_OUT-1:0] lutRead_q;
    logic [WIDTH_OUT-1:0] litWord_q;
    logic                 litSel_q;
    logic                 pushOut_q;

    // Flags come straight from the registered occupancy, so a dequeue on
    // the same edge cannot make room for a push that sees full.
    assign isPush     = (push_code == PC_SYM) || (push_code == PC_LIT);
    assign isLutWrite = (push_code == PC_LUT);
    assign full       = (fifoCount == CW'(FIFO_DEPTH));
    assign half_full  = (fifoCount >= CW'(FIFO_DEPTH / 2));
    assign fifoPush   = isPush && !full;
    assign fifoDin    = {(push_code == PC_LIT) ? TAG_LITERAL : TAG_LOOKUP, d};
    assign fire       = valid1_q && !stall;
    assign fifoPop    = !fifoEmpty && (!valid1_q || !stall);

    sd_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .din_i   (fifoDin),
        .dout_o  (fifoDout),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // S1 refills from the FIFO head whenever it is empty or emitting this
    // cycle; otherwise it holds its entry across a stall.
    always_comb begin
        valid1_d = valid1_q;
        tag1_d   = tag1_q;
        sym1_d   = sym1_q;
        if (fifoPop) begin
            valid1_d = 1'b1;
            tag1_d   = fifoDout[WIDTH_IN];
            sym1_d   = fifoDout[WIDTH_IN-1:0];
        end else if (fire) begin
            valid1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q <= 1'b0;
            tag1_q   <= TAG_LOOKUP;
            sym1_q   <= '0;
        end else begin
            valid1_q <= valid1_d;
            tag1_q   <= tag1_d;
            sym1_q   <= sym1_d;
        end
    end

    // LUT write port and write-address counter; the counter wraps at the
    // table size. The table itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst && isLutWrite) begin
            lut[lutCounter_q] <= WIDTH_OUT'(d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lutCounter_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (isLutWrite) begin
                lutCounter_q <= lutCounter_q + WIDTH_IN'(1);
            end
            if (isPush && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Registered LUT read addressed from S1 so the table maps onto block
    // RAM. A write to the same address on the same edge lands after this
    // read, giving read-before-write.
    always_ff @(posedge clk) begin
        if (fire) begin
            lutRead_q <= lut[sym1_q];
        end
    end

    // Output side: the literal path and the select are registered next to
    // the RAM output. Reset selects the zeroed literal word so q reads 0
    // without needing to reset the RAM read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pushOut_q <= 1'b0;
            litSel_q  <= 1'b1;
            litWord_q <= '0;
        end else begin
            pushOut_q <= fire;
            if (fire) begin
                litSel_q  <= (tag1_q == TAG_LITERAL);
                litWord_q <= WIDTH_OUT'(sym1_q);
            end
        end
    end

    assign q           = litSel_q ? litWord_q : lutRead_q;
    assign push_out    = pushOut_q;
    assign lut_counter = lutCounter_q;
    assign overflow    = overflow_q;

endmodule
